wb_write_arbiter: RTL
=====================

Name: wb_write_arbiter

Overview:
- Producer side of the register-file write port. Merges two result sources into the single `rfwrite` {valid, id, data} channel:
  - the in-order pipeline result, which cannot stall;
  - the multi-cycle mul/div unit result, which can be backpressured.
- Buffers mul/div results in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on RAW/WAW hazards against outstanding mul/div ops.
- Sits between the writeback stage and `regfile`.

Parameters:
- DEPTH, 4, mul/div result FIFO entries; power of two, at least 2.
- CREG_NUM, 32, architectural register count (taken from the common package).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pipe_valid  in  1  pipeline result valid this cycle
- pipe_id  in  5  pipeline destination register
- pipe_data  in  32  pipeline result
- md_valid  in  1  mul/div result offered
- md_ready  out  1  arbiter accepts mul/div result
- md_id  in  5  mul/div destination register
- md_data  in  32  mul/div result
- issue_valid  in  1  decode issues a mul/div op this cycle
- issue_id  in  5  destination of the issued mul/div op
- query_ra1  in  5  decode source register 1
- query_ra2  in  5  decode source register 2
- query_rd  in  5  decode destination register
- busy1  out  1  query_ra1 has a pending mul/div write
- busy2  out  1  query_ra2 has a pending mul/div write
- busy_rd  out  1  query_rd has a pending mul/div write (WAW)
- rf_valid  out  1  register-file write enable
- rf_id  out  5  register-file write index
- rf_data  out  32  register-file write data

Behaviour:
- Reset (synchronous, `reset`=1 at clk edge):
  - FIFO emptied, count=0, scoreboard cleared.
  - Outputs after reset: md_ready=1, rf_valid=0, busy*=0.
  - Reset mid-operation discards buffered results and all pending bits.
- Pipeline path:
  - Combinational pass-through: rf_valid/rf_id/rf_data = pipe_* in the same cycle.
  - Has absolute priority.
- mul/div path:
  - Handshake: transfer when md_valid && md_ready.
  - md_ready = (count < DEPTH). Depends on registered count only and does not look ahead to a same-cycle pop.
  - An accepted entry is written into the FIFO at the clock edge.
- Drain:
  - When pipe_valid=0 and the FIFO is non-empty, the head entry drives rf_* and is popped at the edge.
  - Minimum mul/div-to-regfile latency is 1 cycle.
  - Push and pop in the same cycle: count unchanged. This is legal when full: the pop happens, but no push occurs because md_ready=0.
  - Head and tail pointers wrap modulo DEPTH.
- Register 0:
  - Any write with id=0, from either source, gives rf_valid=0.
  - An id=0 mul/div entry is still popped.
  - issue_id=0 never sets a pending bit.
- Scoreboard (one bit per register, 1..CREG_NUM-1):
  - Set at the edge when issue_valid and issue_id != 0.
  - Cleared at the edge when a mul/div entry with that id is written to the regfile.
  - Set and clear of the same id in the same cycle: set wins.
  - busy1/busy2/busy_rd are combinational lookups of the registered bits; index 0 always reads 0.
- Precondition (checked by bench assertion, not handled in RTL):
  - decode never issues to a register whose busy_rd=1;
  - the pipeline never writes a register whose pending bit is set.

Optional Feature:
- Macro: WB_MD_BYPASS_EN
- Defined: when pipe_valid=0, the FIFO is empty and md_valid=1:
  - the mul/div result drives rf_* combinationally in the same cycle;
  - it is not pushed;
  - md_ready stays 1;
  - the scoreboard clears at that edge.
- Undefined: every mul/div result goes through the FIFO, so latency is at least 1 cycle.

Decomposition:
- common package:
  - creg_addr_t (5-bit), word_t, CREG_NUM;
  - new wb_req_t struct {valid, id, data}, shared with the `rfwrite` interface.
- Sub-module wb_fifo (parameterised DEPTH, payload wb_req_t):
  - push/pop, full/empty, count.
- Arbiter mux and scoreboard live in wb_write_arbiter.

Test Plan:
- Reset then idle -> rf_valid=0, md_ready=1, busy1=busy2=busy_rd=0 for all query values.
- pipe_valid=1 id=5 data=0x11 in the same cycle as md_valid=1 id=7 data=0x22:
  - cycle 0: rf writes r5=0x11;
  - cycle 1, pipe idle: rf writes r7=0x22.
- issue_id=7 -> busy1=1 for query_ra1=7 from the next cycle; clears in the cycle after r7 is written.
- Hold pipe_valid=1 and push DEPTH mul/div results -> md_ready=0 after the 4th accept. Release the pipeline -> results drain in order, one per cycle, and md_ready returns to 1.
- mul/div write to id=0 with data 0xFFFF_FFFF -> rf_valid=0 and the FIFO still pops. issue_id=0 -> no busy bit set.
- Assert reset with 3 entries buffered and r3 pending -> next cycle: count=0, busy lookup for r3=0, no rf write.
- WB_MD_BYPASS_EN defined, empty FIFO, idle pipe, md id=9 data=0x33 -> rf writes r9=0x33 in the same cycle.

Source files
------------

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types for the register-file write path: register index, data word and
// the {valid, id, data} write request carried on the rfwrite channel.
package wb_write_arbiter_pkg;

    localparam int CREG_NUM = 32;
    localparam int CREG_W   = $clog2(CREG_NUM);

    typedef logic [CREG_W-1:0] creg_addr_t;
    typedef logic [31:0]       word_t;

    typedef struct packed {
        logic       valid;
        creg_addr_t id;
        word_t      data;
    } wb_req_t;

    localparam wb_req_t WB_REQ_IDLE = '{valid: 1'b0, id: '0, data: '0};

    // r0 is hard-wired to zero, so a request aimed at it never reaches the regfile.
    function automatic logic writes_rf(input wb_req_t req);
        return req.valid && (req.id != '0);
    endfunction

endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo: small power-of-two FIFO of wb_req_t entries buffering mul/div results.
// Pointers wrap naturally modulo DEPTH; an occupancy counter gives full/empty.
module wb_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    input  logic    pop,
    output wb_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;
    wb_req_t          mem_q [DEPTH];

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_en);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_en);
        count_d  = count_q + CNT_W'(push_en) - CNT_W'(pop_en);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges the non-stalling pipeline result and buffered mul/div
// results onto the regfile write port, and tracks pending mul/div destinations.
// Optional macro WB_MD_BYPASS_EN lets a mul/div result skip an empty FIFO.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pipe_valid,
    input  creg_addr_t pipe_id,
    input  word_t      pipe_data,
    input  logic       md_valid,
    output logic       md_ready,
    input  creg_addr_t md_id,
    input  word_t      md_data,
    input  logic       issue_valid,
    input  creg_addr_t issue_id,
    input  creg_addr_t query_ra1,
    input  creg_addr_t query_ra2,
    input  creg_addr_t query_rd,
    output logic       busy1,
    output logic       busy2,
    output logic       busy_rd,
    output logic       rf_valid,
    output creg_addr_t rf_id,
    output word_t      rf_data
);

    wb_req_t             md_req, head, sel;
    logic                full, empty;
    logic                push, pop, bypass;
    logic [CREG_NUM-1:0] pend_q, pend_d;

    assign md_req = '{valid: 1'b1, id: md_id, data: md_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (md_req),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    // Ready depends on registered occupancy only; a same-cycle pop does not free a slot.
    assign md_ready = !full;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel    = WB_REQ_IDLE;
        pop    = 1'b0;
        bypass = 1'b0;
        if (pipe_valid) begin
            sel = '{valid: 1'b1, id: pipe_id, data: pipe_data};
        end else if (!empty) begin
            sel = head;
            pop = 1'b1;
        end
`ifdef WB_MD_BYPASS_EN
        else if (md_valid) begin
            sel    = md_req;
            bypass = 1'b1;
        end
`endif
        push = md_valid && md_ready && !bypass;
    end

    assign rf_valid = writes_rf(sel);
    assign rf_id    = sel.id;
    assign rf_data  = sel.data;

    // Clear is applied before set so an issue to the retiring register keeps its bit.
    always_comb begin
        pend_d = pend_q;
        if (pop || bypass) begin
            pend_d[sel.id] = 1'b0;
        end
        if (issue_valid && (issue_id != '0)) begin
            pend_d[issue_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Bit 0 is never set, so a lookup of r0 always reads 0.
    assign busy1   = pend_q[query_ra1];
    assign busy2   = pend_q[query_ra2];
    assign busy_rd = pend_q[query_rd];

endmodule
